// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU states, funct3 legality.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT
    } lsu_state_t;

    // Stores only have signed widths; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic store);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store mask/data/legality on the request side,
// load extraction and sign/zero extension on the response side.
module lsu_align
    import riscv_pkg::*;
#(
    parameter int FAULT_ON_MISALIGN = 1
) (
    input  logic [2:0]  i_funct3,
    input  logic        i_store,
    input  logic [1:0]  i_ea_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_data,
    output logic        o_illegal,
    output logic [1:0]  o_ea_lo,
    input  logic [2:0]  i_rd_funct3,
    input  logic [1:0]  i_rd_lo,
    input  logic [31:0] i_mdata,
    output logic [31:0] o_rdata
);

    logic       w_misalign;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // o_ea_lo carries the force-aligned offset used when misalignment is tolerated.
    always_comb begin
        o_ea_lo    = i_ea_lo;
        w_misalign = 1'b0;
        case (i_funct3)
            F3_H, F3_HU: begin
                if (i_ea_lo[0]) begin
                    w_misalign = 1'b1;
                    o_ea_lo[0] = 1'b0;
                end
            end
            F3_W: begin
                if (i_ea_lo != 2'b00) begin
                    w_misalign = 1'b1;
                    o_ea_lo    = '0;
                end
            end
            default: ;
        endcase
        o_illegal = !f3_legal(i_funct3, i_store) || ((FAULT_ON_MISALIGN != 0) && w_misalign);
    end

    always_comb begin
        o_mask = '0;
        o_data = '0;
        if (i_store) begin
            case (i_funct3)
                F3_B: begin
                    o_mask = 4'b0001 << o_ea_lo;
                    o_data = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_mask = o_ea_lo[1] ? 4'b1100 : 4'b0011;
                    o_data = {2{i_wdata[15:0]}};
                end
                F3_W: begin
                    o_mask = 4'hF;
                    o_data = i_wdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_byte = i_mdata[{i_rd_lo, 3'b000} +: 8];
        w_half = i_rd_lo[1] ? i_mdata[31:16] : i_mdata[15:0];
        case (i_rd_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_mdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE -> ACCESS -> WAIT sequencing around a memory
// with one-cycle registered read latency; all memory-side outputs registered.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int FAULT_ON_MISALIGN = 1
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    input  logic        I_store,
    input  logic [2:0]  I_funct3,
    input  logic [31:0] I_base,
    input  logic [31:0] I_offset,
    input  logic [31:0] I_wdata,
    output logic        O_busy,
    output logic        O_done,
    output logic        O_fault,
    output logic [31:0] O_rdata,
    output logic [31:0] O_addr,
    output logic [31:0] O_data,
    output logic [3:0]  O_mask,
    output logic        O_we,
    input  logic [31:0] I_mdata,
    input  logic        I_stall
);

    lsu_state_t  r_state, w_next;
    logic [31:0] w_ea;
    logic [3:0]  w_mask;
    logic [31:0] w_data;
    logic        w_illegal;
    logic [1:0]  w_ea_lo;
    logic [31:0] w_rdata;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic        r_store;
    logic        r_fault;

    assign w_ea = I_base + I_offset;

    lsu_align #(
        .FAULT_ON_MISALIGN(FAULT_ON_MISALIGN)
    ) u_align (
        .i_funct3    (I_funct3),
        .i_store     (I_store),
        .i_ea_lo     (w_ea[1:0]),
        .i_wdata     (I_wdata),
        .o_mask      (w_mask),
        .o_data      (w_data),
        .o_illegal   (w_illegal),
        .o_ea_lo     (w_ea_lo),
        .i_rd_funct3 (r_f3),
        .i_rd_lo     (r_lo),
        .i_mdata     (I_mdata),
        .o_rdata     (w_rdata)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (I_valid) w_next = w_illegal ? WAIT : ACCESS;
            ACCESS:  if (!I_stall) w_next = WAIT;
            WAIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Faulting requests skip ACCESS, so the memory port is never loaded for them.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_busy  <= 1'b0;
            O_done  <= 1'b0;
            O_fault <= 1'b0;
            O_rdata <= '0;
            O_addr  <= '0;
            O_data  <= '0;
            O_mask  <= '0;
            O_we    <= 1'b0;
            r_f3    <= '0;
            r_lo    <= '0;
            r_store <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            O_done  <= 1'b0;
            O_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (I_valid) begin
                        r_f3    <= I_funct3;
                        r_lo    <= w_ea_lo;
                        r_store <= I_store;
                        r_fault <= w_illegal;
                        O_busy  <= 1'b1;
                        if (!w_illegal) begin
                            O_addr <= {w_ea[31:2], 2'b00};
                            O_mask <= w_mask;
                            O_data <= w_data;
                            O_we   <= I_store;
                        end
                    end
                end
                ACCESS: begin
                    if (!I_stall) O_we <= 1'b0;
                end
                WAIT: begin
                    if (!r_store && !r_fault) O_rdata <= w_rdata;
                    O_done  <= 1'b1;
                    O_fault <= r_fault;
                    O_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
